// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: walks enabled descriptor slots lowest-index first and hands
// each non-empty one to a transfer engine, with abort/drain and error capture.
module dma_desc_sched #(
  parameter int NUM_DESC = 2,
  parameter int ADDR_W   = 32,
  localparam int IDX_W   = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go_i,
  input  logic                       abort_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_src_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_dst_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_bytes_i,
  input  logic [NUM_DESC-1:0]        desc_wr_mode_i,
  input  logic [NUM_DESC-1:0]        desc_rd_mode_i,
  input  logic [NUM_DESC-1:0]        desc_en_i,
  output logic                       xfer_valid_o,
  input  logic                       xfer_ready_i,
  output logic [ADDR_W-1:0]          xfer_src_o,
  output logic [ADDR_W-1:0]          xfer_dst_o,
  output logic [ADDR_W-1:0]          xfer_bytes_o,
  output logic                       xfer_wr_mode_o,
  output logic                       xfer_rd_mode_o,
  output logic [IDX_W-1:0]           xfer_idx_o,
  input  logic                       xfer_done_i,
  input  logic                       xfer_err_i,
  output logic                       xfer_abort_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [IDX_W-1:0]           err_idx_o
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DRAIN, FIN} state_t;

  state_t              state_q;
  logic                go_q;
  logic [NUM_DESC-1:0] pend_q;
  logic                valid_q, abort_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0]   src_q, dst_q, bytes_q;
  logic                wr_q, rd_q;
  logic [IDX_W-1:0]    idx_q, err_idx_q;

  logic                go_edge_d;
  logic                sel_vld_d;
  logic [IDX_W-1:0]    sel_idx_d;
  logic [ADDR_W-1:0]   sel_src_d, sel_dst_d, sel_bytes_d;
  logic                sel_wr_d, sel_rd_d;

  assign go_edge_d = go_i & ~go_q;

  // Priority pick: scanning downwards leaves the lowest pending slot selected.
  always_comb begin
    sel_vld_d = 1'b0;
    sel_idx_d = '0;
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld_d = 1'b1;
        sel_idx_d = IDX_W'(i);
      end
    end
    sel_src_d   = desc_src_i[int'(sel_idx_d)*ADDR_W +: ADDR_W];
    sel_dst_d   = desc_dst_i[int'(sel_idx_d)*ADDR_W +: ADDR_W];
    sel_bytes_d = desc_bytes_i[int'(sel_idx_d)*ADDR_W +: ADDR_W];
    sel_wr_d    = desc_wr_mode_i[sel_idx_d];
    sel_rd_d    = desc_rd_mode_i[sel_idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      bytes_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      idx_q     <= '0;
    end else begin
      go_q <= go_i;
      case (state_q)
        IDLE, FIN: begin
          if (go_edge_d) begin
            pend_q    <= desc_en_i;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (abort_i || !sel_vld_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (sel_bytes_d == '0) begin
            pend_q[sel_idx_d] <= 1'b0;
          end else begin
            src_q   <= sel_src_d;
            dst_q   <= sel_dst_d;
            bytes_q <= sel_bytes_d;
            wr_q    <= sel_wr_d;
            rd_q    <= sel_rd_d;
            idx_q   <= sel_idx_d;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // valid_q is always high here, so ready alone marks the handshake.
          if (xfer_ready_i) begin
            valid_q       <= 1'b0;
            pend_q[idx_q] <= 1'b0;
            if (abort_i) begin
              abort_q <= 1'b1;
              state_q <= DRAIN;
            end else begin
              state_q <= WAIT;
            end
          end else if (abort_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        WAIT: begin
          if (xfer_done_i) begin
            if (xfer_err_i) begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end
            if (xfer_err_i || abort_i) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= SCAN;
            end
          end else if (abort_i) begin
            abort_q <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer_done_i) begin
            if (xfer_err_i) begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xfer_valid_o   = valid_q;
  assign xfer_src_o     = src_q;
  assign xfer_dst_o     = dst_q;
  assign xfer_bytes_o   = bytes_q;
  assign xfer_wr_mode_o = wr_q;
  assign xfer_rd_mode_o = rd_q;
  assign xfer_idx_o     = idx_q;
  assign xfer_abort_o   = abort_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign err_idx_o      = err_idx_q;

endmodule
